seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Sequential restoring divider: unsigned DVD_W-bit dividend / DVS_W-bit divisor.
//   Produces one quotient bit per clock. Inverse companion of the shift-add sequential
//   multiplier: divides that block's product by one of its operands to recover the other
//   (e.g. 56/7 -> 8).
//   Uses the same start/enable style of handshake, so both blocks share one test harness.
// PARAMETERS
//   DVD_W  8  dividend width, quotient width, and number of iteration cycles
//   DVS_W  4  divisor width and remainder width
// PORTS
//   clk_i          in   1      clock, rising edge
//   reset_i        in   1      asynchronous, active-high reset
//   div_enable_i   in   1      start request; sampled only in IDLE
//   dividend_i     in   DVD_W  dividend; captured on the start edge
//   divisor_i      in   DVS_W  divisor; captured on the start edge
//   quotient_o     out  DVD_W  quotient; registered and held until the next result
//   remainder_o    out  DVS_W  remainder; registered and held until the next result
//   busy_o         out  1      high in RUN
//   done_o         out  1      one-cycle pulse in DONE; results valid from this cycle
// BEHAVIOUR
//   Reset: state=IDLE; quotient_o=0, remainder_o=0, busy_o=0, done_o=0.
//     All internal registers (including the counter) are cleared.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: at a rising edge with div_enable_i=1:
//     - capture the operands;
//     - partial remainder R (DVS_W+1 bits) = 0; counter = DVD_W;
//     - go to RUN.
//   RUN: each edge executes one step, MSB first:
//     - R = {R[DVS_W-1:0], next dividend bit};
//     - if R >= {1'b0, divisor}: R = R - divisor and shift in quotient bit 1; else shift in 0;
//     - counter decrements.
//     The edge that completes step DVD_W loads quotient_o and remainder_o = R[DVS_W-1:0],
//     then goes to DONE.
//   DONE: done_o=1 for exactly one cycle; next edge goes unconditionally to IDLE.
//   Latency: done_o is high in the cycle after the DVD_W-th edge following the start edge
//     (DVD_W=8: 8 cycles after start).
//     Restart requires a fresh start sampled in IDLE, at least DVD_W+2 cycles between starts.
//   div_enable_i in RUN or DONE: ignored. Operand changes after capture: no effect.
//   div_enable_i held high continuously: the block restarts from IDLE after each DONE.
//   Outputs change only on the load edge; between results they hold the last values.
//   Invariant for divisor != 0: dividend = quotient*divisor + remainder, and remainder < divisor.
//   Reset mid-RUN: aborts immediately to the reset state; no done_o pulse.
//   Divisor = 0 without the macro: the datapath runs the normal DVD_W steps.
//     Result: quotient_o = all ones, remainder_o = dividend[DVS_W-1:0].
// CONFIGURATION
//   SEQ_DIV_ZERO_DETECT_EN defined:
//     - adds port div_zero_o (out, 1, reset 0).
//     - start with divisor_i=0: skip RUN; the next edge goes to DONE.
//     - loads quotient_o = all ones, remainder_o = 0, div_zero_o = 1.
//     - div_zero_o is cleared on the next valid start.
//     - latency for divisor 0 is 1 cycle.
//   Not defined: no div_zero_o port; divisor 0 behaves as described in BEHAVIOUR.
// TESTING
//   1. reset_i=1 for 40ns, then released -> all outputs 0, busy_o=0.
//   2. 56 / 7 with a one-cycle enable -> 8 cycles later done_o=1 for 1 cycle;
//      quotient_o=8, remainder_o=0.
//   3. 225/15 -> q=15, r=0; 200/9 -> q=22, r=2; 255/1 -> q=255, r=0; 5/9 -> q=0, r=5.
//      Each result is held until the next start.
//   4. Start 200/9; pulse enable with 100/3 during RUN -> result is 200/9 (q=22, r=2).
//      A subsequent start in IDLE gives q=33, r=1.
//   5. Assert reset_i at step 4 of 56/7 -> outputs 0 at once, no done_o.
//      After release, 56/7 -> q=8, r=0.
//   6. 77 / 0 without the macro -> after 8 cycles q=255, r=13.
//      With SEQ_DIV_ZERO_DETECT_EN -> after 1 cycle q=255, r=0, div_zero_o=1.
//      div_zero_o clears on the next start of 56/7.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider
//   Sequential restoring divider: unsigned DVD_W-bit dividend divided by a
//   DVS_W-bit divisor, one quotient bit per clock, MSB first. Shares the
//   start/enable handshake of the shift-add sequential multiplier.
//
//   Optional feature macro: SEQ_DIV_ZERO_DETECT_EN
//     When defined, a start with divisor 0 skips the iteration, goes straight
//     to DONE with quotient all ones, remainder 0 and raises div_zero_o.
//
// Ports
//   clk_i         in   1      clock, rising edge
//   reset_i       in   1      asynchronous active-high reset
//   div_enable_i  in   1      start request, sampled only in IDLE
//   dividend_i    in   DVD_W  dividend, captured on the start edge
//   divisor_i     in   DVS_W  divisor, captured on the start edge
//   quotient_o    out  DVD_W  quotient, held until the next result
//   remainder_o   out  DVS_W  remainder, held until the next result
//   busy_o        out  1      high while iterating (RUN)
//   done_o        out  1      one-cycle pulse, results valid from this cycle
//   div_zero_o    out  1      (macro only) last start had divisor 0
module seq_divider #(
  parameter int DVD_W = 8,
  parameter int DVS_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             div_enable_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVD_W-1:0] quotient_o,
  output logic [DVS_W-1:0] remainder_o,
  output logic             busy_o,
  output logic             done_o
`ifdef SEQ_DIV_ZERO_DETECT_EN
  ,
  output logic             div_zero_o
`endif
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after DVD_W steps this register holds the complete quotient.
  logic [DVD_W-1:0] shift_q, shift_d;
  logic [DVS_W:0]   rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [DVS_W-1:0] remout_q, remout_d;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic             dz_q, dz_d;
`endif

  // One restoring step.
  logic [DVS_W:0] trial;
  logic [DVS_W:0] diff;
  logic           q_bit;

  always_comb begin
    trial = {rem_q[DVS_W-1:0], shift_q[DVD_W-1]};
    diff  = trial - {1'b0, dvs_q};
    q_bit = (trial >= {1'b0, dvs_q});
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    remout_d = remout_q;
`ifdef SEQ_DIV_ZERO_DETECT_EN
    dz_d     = dz_q;
`endif

    case (state_q)
      IDLE: begin
        if (div_enable_i) begin
`ifdef SEQ_DIV_ZERO_DETECT_EN
          if (divisor_i == '0) begin
            // Division by zero short-circuits the iteration entirely.
            quo_d    = '1;
            remout_d = '0;
            dz_d     = 1'b1;
            state_d  = DONE;
          end else begin
            dz_d    = 1'b0;
            shift_d = dividend_i;
            dvs_d   = divisor_i;
            rem_d   = '0;
            cnt_d   = CNT_W'(DVD_W);
            state_d = RUN;
          end
`else
          shift_d = dividend_i;
          dvs_d   = divisor_i;
          rem_d   = '0;
          cnt_d   = CNT_W'(DVD_W);
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        rem_d   = q_bit ? diff : trial;
        shift_d = {shift_q[DVD_W-2:0], q_bit};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Final step: publish the results on this edge.
          quo_d    = {shift_q[DVD_W-2:0], q_bit};
          remout_d = rem_d[DVS_W-1:0];
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      remout_q <= '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      remout_q <= remout_d;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = remout_q;
  assign busy_o      = (state_q == RUN);
  assign done_o      = (state_q == DONE);
`ifdef SEQ_DIV_ZERO_DETECT_EN
  assign div_zero_o  = dz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Directed-vector bench for seq_divider (DVD_W=8, DVS_W=4). Expected
//   results are pushed to a scoreboard queue when a division is started; a
//   monitor branch pops and compares whenever done_o is seen.
module tb_seq_divider;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       div_enable_i;
  logic [7:0] dividend_i;
  logic [3:0] divisor_i;
  logic [7:0] quotient_o;
  logic [3:0] remainder_o;
  logic       busy_o;
  logic       done_o;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic       div_zero_o;
`endif

  seq_divider #(.DVD_W(8), .DVS_W(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .div_enable_i (div_enable_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
`ifdef SEQ_DIV_ZERO_DETECT_EN
    ,
    .div_zero_o   (div_zero_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pulse enable for one cycle with the given operands; returns just after
  // the start edge.
  task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs,
                          input logic [7:0] q, input logic [3:0] r, input bit push);
    exp_t e;
    logic busy_req;
    @(posedge clk_i); #1;
    div_enable_i = 1'b1;
    dividend_i   = dvd;
    divisor_i    = dvs;
    if (push) begin
      e.q = q;
      e.r = r;
      sb.push_back(e);
    end
    @(posedge clk_i); #1;
    div_enable_i = 1'b0;
    busy_req = 1'b1;
`ifdef SEQ_DIV_ZERO_DETECT_EN
    if (dvs == 4'd0) busy_req = 1'b0;
`endif
    chk($sformatf("busy_after_start_%0d_%0d", dvd, dvs), busy_o, busy_req);
  endtask

  // Count edges after the start edge until done_o; then check the pulse is
  // one cycle wide and the result is held.
  task automatic wait_done(input string name, input int exp_edges,
                           input logic [7:0] q, input logic [3:0] r);
    int n = 0;
    while (done_o !== 1'b1 && n < 40) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({name, "_latency"}, n, exp_edges);
    if (done_o === 1'b1) begin
      @(posedge clk_i); #1;
      chk({name, "_done_one_cycle"}, done_o, 1'b0);
      chk({name, "_q_held"}, quotient_o, q);
      chk({name, "_r_held"}, remainder_o, r);
    end
  endtask

  initial begin
    reset_i      = 1'b1;
    div_enable_i = 1'b0;
    dividend_i   = 8'd0;
    divisor_i    = 4'd0;

    fork
      // Monitor: compare each presented result against the scoreboard.
      begin
        exp_t e;
        forever begin
          @(negedge clk_i);
          if (done_o === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
              bad++;
              $display("FAIL unexpected_done actual q=%0d r=%0d required=no result", quotient_o, remainder_o);
            end else begin
              e = sb.pop_front();
              if (quotient_o !== e.q || remainder_o !== e.r) begin
                bad++;
                $display("FAIL result actual q=%0d r=%0d required q=%0d r=%0d", quotient_o, remainder_o, e.q, e.r);
              end else begin
                $display("result q=%0d r=%0d ok", quotient_o, remainder_o);
              end
            end
          end
        end
      end

      // Stimulus.
      begin
        // 1. reset
        #35;
        chk("reset_q_during", quotient_o, 8'd0);
        #5 reset_i = 1'b0;
        #1;
        chk("reset_q", quotient_o, 8'd0);
        chk("reset_r", remainder_o, 4'd0);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
`ifdef SEQ_DIV_ZERO_DETECT_EN
        chk("reset_div_zero", div_zero_o, 1'b0);
`endif

        // 2. basic
        start_op(8'd56, 4'd7, 8'd8, 4'd0, 1'b1);
        wait_done("div_56_7", 8, 8'd8, 4'd0);

        // 3. assorted vectors
        start_op(8'd225, 4'd15, 8'd15, 4'd0, 1'b1);
        wait_done("div_225_15", 8, 8'd15, 4'd0);
        start_op(8'd200, 4'd9, 8'd22, 4'd2, 1'b1);
        wait_done("div_200_9", 8, 8'd22, 4'd2);
        start_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b1);
        wait_done("div_255_1", 8, 8'd255, 4'd0);
        start_op(8'd5, 4'd9, 8'd0, 4'd5, 1'b1);
        wait_done("div_5_9", 8, 8'd0, 4'd5);
        repeat (4) @(posedge clk_i);
        #1;
        chk("hold_q_idle", quotient_o, 8'd0);
        chk("hold_r_idle", remainder_o, 4'd5);

        // 4. enable and operand changes during RUN are ignored
        start_op(8'd200, 4'd9, 8'd22, 4'd2, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        div_enable_i = 1'b1;
        dividend_i   = 8'd100;
        divisor_i    = 4'd3;
        @(posedge clk_i); #1;
        div_enable_i = 1'b0;
        wait_done("div_ignore_en", 5, 8'd22, 4'd2);
        start_op(8'd100, 4'd3, 8'd33, 4'd1, 1'b1);
        wait_done("div_100_3", 8, 8'd33, 4'd1);

        // 5. reset mid-RUN aborts with no done pulse
        start_op(8'd56, 4'd7, 8'd8, 4'd0, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        #1;
        chk("midreset_q", quotient_o, 8'd0);
        chk("midreset_r", remainder_o, 4'd0);
        chk("midreset_busy", busy_o, 1'b0);
        chk("midreset_done", done_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1;
        chk("midreset_no_result_q", quotient_o, 8'd0);
        start_op(8'd56, 4'd7, 8'd8, 4'd0, 1'b1);
        wait_done("div_56_7_after_reset", 8, 8'd8, 4'd0);

        // 6. divide by zero
`ifdef SEQ_DIV_ZERO_DETECT_EN
        start_op(8'd77, 4'd0, 8'd255, 4'd0, 1'b1);
        // done already visible right after the start edge: zero further edges
        wait_done("div_77_0", 0, 8'd255, 4'd0);
        chk("div_zero_set", div_zero_o, 1'b1);
        start_op(8'd56, 4'd7, 8'd8, 4'd0, 1'b1);
        chk("div_zero_cleared", div_zero_o, 1'b0);
        wait_done("div_56_7_post_zero", 8, 8'd8, 4'd0);
`else
        start_op(8'd77, 4'd0, 8'd255, 4'd13, 1'b1);
        wait_done("div_77_0", 8, 8'd255, 4'd13);
`endif

        // 7. enable held high: restarts after each DONE (10-cycle period)
        @(posedge clk_i); #1;
        div_enable_i = 1'b1;
        dividend_i   = 8'd200;
        divisor_i    = 4'd9;
        sb.push_back('{q: 8'd22, r: 4'd2});
        sb.push_back('{q: 8'd22, r: 4'd2});
        repeat (12) @(posedge clk_i);
        #1;
        div_enable_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1;
        chk("continuous_busy_idle", busy_o, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
      end
    join_any

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
